// File: rtl/sermul_pkg.sv
// sermul_pkg: shared widths, FSM state type and slot-counter type for the
// sermul_host front end and its capture sub-module.
//   OPW     operand width (bits per serial operand)
//   RESW    product width (bits collected from the serial output)
//   LAT_MAX largest supported multiplier latency
//   CNT_W   slot-counter width, wide enough for slot LAT_MAX+RESW-1
package sermul_pkg;

  localparam int OPW     = 4;
  localparam int RESW    = 8;
  localparam int LAT_MAX = 7;
  localparam int CNT_W   = $clog2(LAT_MAX + RESW);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef logic [CNT_W-1:0] slot_t;

endpackage

// File: rtl/sermul_host_if.sv
// sermul_host_if: bundles the parallel operand/product handshakes and the
// serial multiplier pins of sermul_host.
//   slave  modport: used by sermul_host (accepts operands, drives A/B/SYNC,
//                   reads O, returns the product)
//   master modport: used by the bus master / test environment
// Signals: in_valid/in_ready/opa/opb, a/b/sync/o, out_valid/out_ready/res/err.
interface sermul_host_if;
  import sermul_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  opa;
  logic [OPW-1:0]  opb;
  logic            a;
  logic            b;
  logic            sync;
  logic            o;
  logic            out_valid;
  logic            out_ready;
  logic [RESW-1:0] res;
  logic            err;

  modport slave (
    input  in_valid, opa, opb, o, out_ready,
    output in_ready, a, b, sync, out_valid, res, err
  );

  modport master (
    output in_valid, opa, opb, o, out_ready,
    input  in_ready, a, b, sync, out_valid, res, err
  );

endinterface

// File: rtl/sermul_deser.sv
// sermul_deser: product capture register. While the host is busy and the
// current slot lies in [LAT, LAT+RESW-1], the serial bit is shifted in at the
// MSB, so the bit captured in slot LAT+k ends up in data_o[k].
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset (clears the captured product)
//   busy_i  host is serializing a frame
//   slot_i  current frame slot
//   bit_i   serial product bit O
//   data_o  captured product
module sermul_deser
  import sermul_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            busy_i,
  input  slot_t           slot_i,
  input  logic            bit_i,
  output logic [RESW-1:0] data_o
);

  logic [RESW-1:0] data_q;
  logic [RESW-1:0] data_d;
  logic            in_win;

  // Compared as int so LAT=0 does not collapse into a constant-true compare.
  assign in_win = (int'(slot_i) >= LAT) && (int'(slot_i) < LAT + RESW);

  always_comb begin
    data_d = data_q;
    if (busy_i && in_win) begin
      data_d = {bit_i, data_q[RESW-1:1]};
    end
  end

  // NOTE: the product register is plain flops, not a memory, so it takes
  // the synchronous reset like every other piece of state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/sermul_host.sv
// sermul_host: host-side front end for the 4-bit bit-serial multiplier.
// Accepts an operand pair on in_valid/in_ready, drives them LSB-first on A/B
// with SYNC marking slot 0, collects the serial product from O after LAT
// slots and returns it on out_valid/out_ready. One operation in flight.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset (also resets the multiplier)
//   bus    sermul_host_if.slave (operand, serial and product signals)
// Parameter LAT (0..7): slots between a product bit's frame slot and O.
// Optional feature: define SERMUL_HOST_CHECK_EN to compare the collected
// product against a parallel reference and flag a mismatch on err.
module sermul_host
  import sermul_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sermul_host_if.slave       bus
);

  localparam int    N    = LAT + RESW;
  localparam slot_t LAST = slot_t'(N - 1);

  state_e         state_q, state_d;
  slot_t          slot_q, slot_d;
  logic [OPW-1:0] opa_sh_q, opa_sh_d;
  logic [OPW-1:0] opb_sh_q, opb_sh_d;
  logic           a_q, a_d;
  logic           b_q, b_d;
  logic           sync_q, sync_d;

  // Operands are kept as right-shifting registers: bit 0 feeds the next slot
  // and zeros fill in, so A/B fall to 0 from slot OPW onwards by themselves.
  // NOTE: every _d gets its default before the case, so no path can leave a
  // variable unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    opa_sh_d = opa_sh_q;
    opb_sh_d = opb_sh_q;
    a_d      = 1'b0;
    b_d      = 1'b0;
    sync_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d  = BUSY;
          slot_d   = '0;
          a_d      = bus.opa[0];
          b_d      = bus.opb[0];
          sync_d   = 1'b1;
          opa_sh_d = bus.opa >> 1;
          opb_sh_d = bus.opb >> 1;
        end
      end
      BUSY: begin
        if (slot_q == LAST) begin
          state_d = DONE;
          slot_d  = '0;
        end else begin
          slot_d   = slot_q + 1'b1;
          a_d      = opa_sh_q[0];
          b_d      = opb_sh_q[0];
          opa_sh_d = opa_sh_q >> 1;
          opb_sh_d = opb_sh_q >> 1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      opa_sh_q <= '0;
      opb_sh_q <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      opa_sh_q <= opa_sh_d;
      opb_sh_q <= opb_sh_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sync_q   <= sync_d;
    end
  end

  sermul_deser #(.LAT(LAT)) u_deser (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .busy_i (state_q == BUSY),
    .slot_i (slot_q),
    .bit_i  (bus.o),
    .data_o (bus.res)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.sync      = sync_q;

`ifdef SERMUL_HOST_CHECK_EN
  logic [RESW-1:0] ref_q, ref_d;

  always_comb begin
    ref_d = ref_q;
    if (bus.in_valid && state_q == IDLE) begin
      ref_d = RESW'(bus.opa) * RESW'(bus.opb);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ref_q <= '0;
    end else begin
      ref_q <= ref_d;
    end
  end

  // The product register is frozen in DONE, so the compare is stable there.
  assign bus.err = (state_q == DONE) && (bus.res != ref_q);
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: doc/sermul_host.md
# sermul_host

Host-side front end for the 4-bit bit-serial multiplier. Accepts a pair of 4-bit parallel operands on a valid/ready handshake and serializes them LSB-first onto the multiplier's A and B inputs. Collects the multiplier's serial output O into an 8-bit product and returns it on a second valid/ready handshake. Sits between a parallel bus master and the serial datapath; one operation in flight at a time.

## Interface
- LAT, 2: cycles from a serial product bit's frame slot to its appearance on O (legal 0..7)
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- IN_VALID  in  1  operand pair valid
- IN_READY  out  1  block can accept operands
- OPA  in  4  multiplicand
- OPB  in  4  multiplier
- A  out  1  serial multiplicand to multiplier
- B  out  1  serial multiplier operand to multiplier
- SYNC  out  1  high during frame slot 0
- O  in  1  serial product from multiplier
- OUT_VALID  out  1  product valid
- OUT_READY  in  1  consumer accepts product
- RES  out  8  captured product
- ERR  out  1  product mismatch flag (see Configuration)

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE.
- Reset values: IN_READY=1 (IDLE), A=B=SYNC=0, OUT_VALID=0, RES=0, ERR=0, slot counter=0.
- IDLE: IN_READY=1. IN_VALID&IN_READY at an edge latches OPA/OPB → BUSY, counter t=0.
- BUSY: counter t runs 0..N-1, N=LAT+8. IN_READY=0.
  - A=OPA[t], B=OPB[t] for t<4; A=B=0 for t≥4. A, B, SYNC are registered.
  - SYNC=1 only in t=0.
  - O sampled at the edge ending slot t; for t=k+LAT with k in 0..7, RES[k] ← O. Slots t<LAT are ignored.
  - At t=N-1 → DONE.
- DONE: OUT_VALID=1, RES stable. OUT_VALID&OUT_READY → IDLE; OUT_VALID drops the next cycle.
- No accept is possible in DONE; a new operation starts only from IDLE.
- Arithmetic: unsigned; RES = OPA×OPB, maximum 0xE1. No overflow is possible.
- IN_VALID during BUSY/DONE is ignored. OPA/OPB changes after accept have no effect.
- RST mid-frame: next state IDLE, all outputs at reset values, operands and partial RES discarded. The multiplier is reset by the same RST.

## Timing
- Accept edge e0 → A/B slot 0 valid in the cycle after e0.
- OUT_VALID rises N=LAT+8 edges after e0.
- Minimum period per operation: LAT+10 cycles (accept, N BUSY slots, one DONE cycle with OUT_READY=1).
- OUT_READY held low: DONE holds indefinitely with RES and OUT_VALID stable.
- IN_READY is low from the cycle after accept until the cycle after the product handshake.

## Configuration
- SERMUL_HOST_CHECK_EN defined: a parallel OPA×OPB reference is computed at accept. On entering DONE, ERR=1 if RES≠reference, otherwise ERR=0. ERR stays valid through DONE and clears on the handshake.
- Not defined: ERR tied 0 and no multiplier logic is inferred.

## Structure
- Package sermul_pkg:
  - OPW=4, RESW=8
  - state enum {IDLE, BUSY, DONE}
  - counter width derived from the maximum LAT+8.
- One sub-module, sermul_deser: an 8-bit capture register enabled in window t∈[LAT, LAT+7], shifting O in at the MSB so that bit k lands in RES[k].
- The top level holds the FSM, slot counter, operand registers and the optional checker.

## Test plan
- LAT=2, OPA=3, OPB=5, reference multiplier model → A shows 1,1,0,0,0…; B shows 1,0,1,0,0…; RES=0x0F; OUT_VALID at e0+10.
- OPA=15, OPB=15 → RES=0xE1. OPA=0, OPB=9 → RES=0x00.
- OUT_READY low for 5 cycles in DONE → RES/OUT_VALID stable, IN_READY=0 throughout; handshake then returns to IDLE next cycle.
- RST asserted at t=4 of a frame → next cycle: IDLE, IN_READY=1, A=B=SYNC=0, RES=0. A following 2×7 op gives RES=0x0E.
- With SERMUL_HOST_CHECK_EN, O forced to 0 with OPA=3, OPB=5 → RES=0x00, ERR=1. With a correct model → ERR=0. Without the macro, ERR=0 always.
- LAT=0 and LAT=7 builds with OPA=9, OPB=6 → RES=0x36; OUT_VALID at e0+8 and e0+15 respectively.
